// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_W_DEF  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } wb_state_e;

    // Requester index: 0 = ALU writeback, 1 = load writeback.
    typedef logic req_idx_t;

    function automatic logic [7:0] dec3to8(input logic [2:0] num);
        dec3to8 = 8'b1 << num;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer only moves on a contested acceptance.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     valid0,
    input  logic     valid1,
    input  logic     advance,
    output req_idx_t grant
);

    req_idx_t rr;

    // A lone valid wins outright; with no valid the grant idles on requester 0.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = rr;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (advance) begin
            rr <= ~grant;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters into a one-entry stage feeding the register file write port.
// Optional macro REGFILE_WB_SCOREBOARD_EN enables the pend_mask scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_W  = NUM_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [NUM_W-1:0]     req0_num,
    input  logic [DATA_W-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [NUM_W-1:0]     req1_num,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 req1_ready,
    input  logic                 wb_hold,
    output logic                 rf_write,
    output logic [NUM_W-1:0]     rf_writenum,
    output logic [DATA_W-1:0]    rf_data_in,
    output logic [2**NUM_W-1:0]  pend_mask,
    output wb_state_e            state_dbg
);

    // Handshake: a request transfers on a rising clk edge where valid & ready are both 1;
    // ready never depends on the same requester's num/data, and a requester holds its
    // valid/num/data stable until it is accepted.

    wb_state_e          state, state_next;
    logic [NUM_W-1:0]   stage_num;
    logic [DATA_W-1:0]  stage_data;
    req_idx_t           grant;
    logic               stage_free;
    logic               contested;
    logic               accept;

    assign stage_free = (state == IDLE) | ((state == HELD) & !wb_hold);
    assign contested  = req0_valid & req1_valid;
    assign accept     = stage_free & (req0_valid | req1_valid);
    assign req0_ready = stage_free & (grant == 1'b0);
    assign req1_ready = stage_free & (grant == 1'b1);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .advance (stage_free & contested),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!wb_hold) begin
                    state_next = accept ? HELD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Draining and refilling happen on the same edge, giving one write per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_num  <= '0;
            stage_data <= '0;
        end else if (accept) begin
            if (grant == 1'b1) begin
                stage_num  <= req1_num;
                stage_data <= req1_data;
            end else begin
                stage_num  <= req0_num;
                stage_data <= req0_data;
            end
        end
    end

    assign rf_write    = (state == HELD) & !wb_hold;
    assign rf_writenum = (state == HELD) ? stage_num : '0;
    assign rf_data_in  = (state == HELD) ? stage_data : '0;
    assign state_dbg   = state;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam int MASK_W = 2**NUM_W;
    generate
        if (NUM_W == 3) begin : g_dec
            logic [7:0] onehot;
            assign onehot    = dec3to8(rf_writenum);
            assign pend_mask = (state == HELD) ? onehot : '0;
        end else begin : g_shift
            logic [MASK_W-1:0] one;
            assign one       = {{(MASK_W-1){1'b0}}, 1'b1};
            assign pend_mask = (state == HELD) ? (one << rf_writenum) : '0;
        end
    endgenerate
`else
    assign pend_mask = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model, expected-write queue, directed and random phases.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DW = 16;
    localparam int NW = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req0_valid = 1'b0;
    logic [NW-1:0]  req0_num = '0;
    logic [DW-1:0]  req0_data = '0;
    logic           req0_ready;
    logic           req1_valid = 1'b0;
    logic [NW-1:0]  req1_num = '0;
    logic [DW-1:0]  req1_data = '0;
    logic           req1_ready;
    logic           wb_hold = 1'b0;
    logic           rf_write;
    logic [NW-1:0]  rf_writenum;
    logic [DW-1:0]  rf_data_in;
    logic [7:0]     pend_mask;
    wb_state_e      dut_state;

    regfile_wb_arbiter #(.DATA_W(DW), .NUM_W(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_num    (req0_num),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_num    (req1_num),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .wb_hold     (wb_hold),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_data_in  (rf_data_in),
        .pend_mask   (pend_mask),
        .state_dbg   (dut_state)
    );

    always #5 clk = ~clk;

    // Entries are {num, data}.
    logic [NW+DW-1:0] exp_q[$];
    logic [NW+DW-1:0] src0_q[$];
    logic [NW+DW-1:0] src1_q[$];
    logic [NW-1:0]    wr_log[$];
    logic [DW-1:0]    rf_mem[8];

    logic             m_state;
    logic             m_rr;
    logic [NW-1:0]    m_num;
    logic [DW-1:0]    m_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pend();
`ifdef REGFILE_WB_SCOREBOARD_EN
        return m_state ? (8'b1 << m_num) : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic apply_srcs();
        req0_valid = (src0_q.size() > 0);
        if (req0_valid) {req0_num, req0_data} = src0_q[0];
        req1_valid = (src1_q.size() > 0);
        if (req1_valid) {req1_num, req1_data} = src1_q[0];
    endtask

    // One clock: present sources, compare against the model, advance the model, cross the edge.
    task automatic cycle();
        logic free;
        logic g;
        logic [NW+DW-1:0] w;
        apply_srcs();
        #1;
        free = !m_state || !wb_hold;
        g = (req0_valid && req1_valid) ? m_rr : req1_valid;
        check("ready0", req0_ready, free && !g);
        check("ready1", req1_ready, free && g);
        check("state", dut_state, m_state);
        check("rf_write", rf_write, m_state && !wb_hold);
        check("rf_writenum", rf_writenum, m_state ? m_num : 3'd0);
        check("rf_data_in", rf_data_in, m_state ? m_data : 16'd0);
        check("pend_mask", pend_mask, exp_pend());
        if (rf_write) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {rf_writenum, rf_data_in}, 0);
            end else begin
                w = exp_q.pop_front();
                check("sb_write", {rf_writenum, rf_data_in}, w);
            end
            rf_mem[rf_writenum] = rf_data_in;
            wr_log.push_back(rf_writenum);
        end
        if (free && (req0_valid || req1_valid)) begin
            w = g ? src1_q.pop_front() : src0_q.pop_front();
            exp_q.push_back(w);
            {m_num, m_data} = w;
            m_state = 1'b1;
            if (req0_valid && req1_valid) m_rr = !g;
        end else if (free) begin
            m_state = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        wb_hold = 1'b0;
        apply_srcs();
        reset = 1'b1;
        #1;
        check("rst_rf_write", rf_write, 0);
        check("rst_writenum", rf_writenum, 0);
        check("rst_data_in", rf_data_in, 0);
        check("rst_pend_mask", pend_mask, 0);
        check("rst_ready0", req0_ready, 1);
        check("rst_ready1", req1_ready, 0);
        m_state = 1'b0;
        m_rr    = 1'b0;
        m_num   = '0;
        m_data  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_log.delete();
    endtask

    initial begin
        logic [DW-1:0] r7_before;
        int exp_order[4];
        int guard;
        for (int i = 0; i < 8; i++) rf_mem[i] = '0;
        exp_order = '{1, 2, 1, 2};

        do_reset();

        // Single ALU writeback lands one cycle after acceptance.
        src0_q.push_back({3'd3, 16'h00AA});
        cycle();
        check("r27_write", rf_write, 1);
        check("r27_num", rf_writenum, 3);
        check("r27_data", rf_data_in, 16'h00AA);
        cycle();
        check("r27_readback", rf_mem[3], 16'h00AA);

        // Constant contention alternates grants.
        do_reset();
        src0_q.push_back({3'd1, 16'h0101});
        src0_q.push_back({3'd1, 16'h0102});
        src1_q.push_back({3'd2, 16'h0201});
        src1_q.push_back({3'd2, 16'h0202});
        for (int i = 0; i < 6; i++) cycle();
        check("r28_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) check("r28_order", wr_log[i], exp_order[i]);

        // Hold freezes the stage and both readies.
        do_reset();
        src0_q.push_back({3'd6, 16'h1234});
        cycle();
        src1_q.push_back({3'd2, 16'h5678});
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("r29_held_num", rf_writenum, 6);
        wb_hold = 1'b0;
        cycle();
        cycle();
        check("r29_r6", rf_mem[6], 16'h1234);
        check("r29_r2", rf_mem[2], 16'h5678);

        // Same-register contention: grant order decides the final value.
        do_reset();
        src0_q.push_back({3'd5, 16'h1111});
        src1_q.push_back({3'd5, 16'h2222});
        for (int i = 0; i < 4; i++) cycle();
        check("r30_r5", rf_mem[5], 16'h2222);
        check("r30_count", wr_log.size(), 2);

        // Reset while holding a write to R7 drops it.
        do_reset();
        r7_before = rf_mem[7];
        src0_q.push_back({3'd7, 16'hBEEF});
        cycle();
        check("r31_held", rf_writenum, 7);
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        check("r31_r7", rf_mem[7], r7_before);

        // Scoreboard mask for a held write to R4.
        do_reset();
        src0_q.push_back({3'd4, 16'h4444});
        cycle();
`ifdef REGFILE_WB_SCOREBOARD_EN
        check("r32_pend", pend_mask, 8'b0001_0000);
`else
        check("r32_pend", pend_mask, 8'h00);
`endif
        cycle();

        // Random traffic with random hold.
        for (int i = 0; i < 300; i++) begin
            if (src0_q.size() < 3 && $urandom_range(0, 1) == 1)
                src0_q.push_back({3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535))});
            if (src1_q.size() < 3 && $urandom_range(0, 1) == 1)
                src1_q.push_back({3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535))});
            wb_hold = ($urandom_range(0, 3) == 0);
            cycle();
        end
        wb_hold = 1'b0;
        guard = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || m_state) && guard < 40) begin
            cycle();
            guard++;
        end
        if (guard >= 40) check("drain_timeout", 1, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: register data width, equal to the register file width.
REQ-002 The block SHALL have parameter NUM_W, default 3: register number width, 8 registers.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid  input  1; req0_num  input  NUM_W; req0_data  input  DATA_W  requester 0 (ALU writeback).
REQ-006 The block SHALL have port req0_ready  output  1  requester 0 accepted when valid&ready at a clk edge.
REQ-007 The block SHALL have ports req1_valid, req1_num, req1_data, req1_ready, defined as for requester 0 (load writeback).
REQ-008 The block SHALL have port wb_hold  input  1  stalls drain of the output stage.
REQ-009 The block SHALL have ports rf_write  output  1; rf_writenum  output  NUM_W; rf_data_in  output  DATA_W  these drive the register file write port.
REQ-010 The block SHALL have port pend_mask  output  2**NUM_W  scoreboard of registers with a write held in the output stage (see REQ-024).

Function
REQ-011 FSM states: IDLE (stage empty) and HELD (stage holds one accepted write).
REQ-012 Ready rule: reqN_ready SHALL be combinational: stage_free = (state==IDLE) | (state==HELD & !wb_hold), and reqN_ready = stage_free & granted(N).
REQ-013 Grant: if only one valid, it is granted; if both valid, the requester named by the round-robin pointer rr is granted.
REQ-014 rr SHALL flip to the non-granted requester only on a cycle where a contested (both-valid) acceptance occurs; otherwise it holds.
REQ-015 Acceptance loads {num, data} into the stage at the clk edge; latency from acceptance to rf_write = 1 cycle.
REQ-016 rf_write SHALL be 1 exactly when state==HELD & !wb_hold; rf_writenum/rf_data_in SHALL equal the stage contents while HELD, and 0 while IDLE.
REQ-017 Transitions: IDLE->HELD on acceptance; HELD->HELD on drain with simultaneous acceptance (back-to-back, one write per cycle); HELD->IDLE on drain without acceptance; HELD holds while wb_hold=1.
REQ-018 While wb_hold=1 in HELD, both readies SHALL be 0 and the stage SHALL be unchanged.
REQ-019 A non-granted requester SHALL keep ready=0; its valid/num/data must remain stable until accepted (the block relies on this, no internal buffering).
REQ-020 Both requesters targeting the same register in one cycle: only the granted write is accepted; the other follows in a later cycle, giving order by grant.
REQ-021 Sustained throughput with wb_hold=0: one write per cycle; under constant contention, grants alternate 0,1,0,1.

Reset
REQ-022 Asserting reset SHALL immediately force state=IDLE, rr=0 (requester 0 preferred), stage cleared, rf_write=0, rf_writenum=0, rf_data_in=0, pend_mask=0, readies per REQ-012 from the IDLE state.
REQ-023 Reset mid-operation SHALL drop any held write without issuing it; operation resumes on the first clk edge after deassertion.

Configuration
REQ-024 With macro REGFILE_WB_SCOREBOARD_EN defined, pend_mask SHALL be the one-hot of rf_writenum while HELD, and 0 while IDLE; without it, the pend_mask port SHALL still exist, tied to 0, with no scoreboard logic.

Structure
REQ-025 DATA_W/NUM_W defaults, the FSM state enum (IDLE, HELD) and the requester-index type SHALL live in shared package regfile_pkg.
REQ-026 The grant logic SHALL be a sub-module rr_arbiter2 (inputs valid0, valid1, advance; output grant; internal rr flop); the number-to-one-hot conversion SHALL reuse the existing 3:8 decoder.

Verification
REQ-027 Reset then req0 {num=3, data=16'h00AA} -> ready0=1 same cycle; next cycle rf_write=1, rf_writenum=3, rf_data_in=16'h00AA; R3 reads back 16'h00AA.
REQ-028 Both valid for 4 cycles after reset (req0 num=1, req1 num=2), wb_hold=0 -> writes 1,2,1,2 on consecutive cycles.
REQ-029 HELD with wb_hold=1 for 3 cycles -> rf_write=0, both readies=0, stage unchanged; on release, the held write issues in the next cycle.
REQ-030 Both target R5 (req0 data=16'h1111, req1 data=16'h2222), rr=0 -> R5 ends at 16'h2222, issued two consecutive cycles.
REQ-031 Assert reset while HELD with num=7 -> rf_write=0 immediately; R7 unchanged; pend_mask=0.
REQ-032 With REGFILE_WB_SCOREBOARD_EN defined, HELD num=4 -> pend_mask=8'b00010000; without the macro, pend_mask=0.
